reg_rename_file: RTL and testbench

Architectural register file with per-register rename status. It sits at the consumer end of the reorder buffer's commit bus: it takes in-order commits (value write plus busy release), records renames from the issue stage, and flushes all renames on a clear. It serves two combinational operand lookups that return either a ready value or the producing ROB tag, with same-cycle commit bypass.

---
 rtl/reg_rename_file_pkg.sv | 12 +
 rtl/reg_rename_file_read_port.sv | 37 +++
 rtl/reg_rename_file.sv | 96 +++++++++
 tb/tb_reg_rename_file.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_rename_file_pkg.sv
// Shared widths for the rename-aware architectural register file.
// The tag width must track the ROB index width so commit tags compare directly.
package reg_rename_file_pkg;
    localparam int REG_NUM = 32;
    localparam int REG_W   = 5;
    localparam int TAG_W   = 5;
    localparam int DATA_W  = 32;

    function automatic logic is_x0(input logic [REG_W-1:0] addr);
        return (addr == '0);
    endfunction
endpackage

// File: rtl/reg_rename_file_read_port.sv
// One operand lookup: x0 forcing, same-cycle commit bypass, else stored state.
// Purely combinational; the top feeds it the stored entry selected by the address.
module regfile_read_port
    import reg_rename_file_pkg::*;
(
    input  logic [REG_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_st_val,
    input  logic              i_st_busy,
    input  logic [TAG_W-1:0]  i_st_tag,
    input  logic              i_commit_en,
    input  logic [REG_W-1:0]  i_commit_rd,
    input  logic [TAG_W-1:0]  i_commit_tag,
    input  logic [DATA_W-1:0] i_commit_val,
    output logic [DATA_W-1:0] o_val,
    output logic              o_busy,
    output logic [TAG_W-1:0]  o_tag
);
    logic w_bypass;

    // Only the commit of the exact pending producer may forward its value.
    assign w_bypass = i_st_busy && i_commit_en && (i_commit_rd == i_addr) &&
                      (i_commit_tag == i_st_tag);

    always_comb begin
        o_val  = i_st_val;
        o_busy = i_st_busy;
        o_tag  = i_st_tag;
        if (is_x0(i_addr)) begin
            o_val  = '0;
            o_busy = 1'b0;
            o_tag  = '0;
        end else if (w_bypass) begin
            o_val  = i_commit_val;
            o_busy = 1'b0;
        end
    end
endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register busy/tag rename state,
// in-order commit release, flush-on-clear, and two bypassing read ports.
module reg_rename_file
    import reg_rename_file_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              commit_en_in,
    input  logic [TAG_W-1:0]  commit_tag_in,
    input  logic [REG_W-1:0]  commit_rd_in,
    input  logic [DATA_W-1:0] commit_val_in,
    input  logic              rename_en_in,
    input  logic [REG_W-1:0]  rename_rd_in,
    input  logic [TAG_W-1:0]  rename_tag_in,
    input  logic [REG_W-1:0]  rs1_addr_in,
    input  logic [REG_W-1:0]  rs2_addr_in,
    output logic [DATA_W-1:0] rs1_val_out,
    output logic [DATA_W-1:0] rs2_val_out,
    output logic              rs1_busy_out,
    output logic              rs2_busy_out,
    output logic [TAG_W-1:0]  rs1_tag_out,
    output logic [TAG_W-1:0]  rs2_tag_out
);
    logic [DATA_W-1:0]  r_val [REG_NUM];
    logic [TAG_W-1:0]   r_tag [REG_NUM];
    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] w_commit_hit;
    logic [REG_NUM-1:0] w_rename_hit;

    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_dec
            if (gi == 0) begin : g_x0
                assign w_commit_hit[gi] = 1'b0;
                assign w_rename_hit[gi] = 1'b0;
            end else begin : g_xn
                assign w_commit_hit[gi] = commit_en_in && (commit_rd_in == REG_W'(gi));
                assign w_rename_hit[gi] = rename_en_in && !clear_in &&
                                          (rename_rd_in == REG_W'(gi));
            end
        end
    endgenerate

    // Entry 0 is only ever reset, so it stays zero and idle forever.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (w_commit_hit[i])
                    r_val[i] <= commit_val_in;
                if (clear_in) begin
                    r_busy[i] <= 1'b0;
                end else if (w_rename_hit[i]) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= rename_tag_in;
                end else if (w_commit_hit[i] && r_busy[i] && (r_tag[i] == commit_tag_in)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    regfile_read_port u_rs1 (
        .i_addr       (rs1_addr_in),
        .i_st_val     (r_val[rs1_addr_in]),
        .i_st_busy    (r_busy[rs1_addr_in]),
        .i_st_tag     (r_tag[rs1_addr_in]),
        .i_commit_en  (commit_en_in),
        .i_commit_rd  (commit_rd_in),
        .i_commit_tag (commit_tag_in),
        .i_commit_val (commit_val_in),
        .o_val        (rs1_val_out),
        .o_busy       (rs1_busy_out),
        .o_tag        (rs1_tag_out)
    );

    regfile_read_port u_rs2 (
        .i_addr       (rs2_addr_in),
        .i_st_val     (r_val[rs2_addr_in]),
        .i_st_busy    (r_busy[rs2_addr_in]),
        .i_st_tag     (r_tag[rs2_addr_in]),
        .i_commit_en  (commit_en_in),
        .i_commit_rd  (commit_rd_in),
        .i_commit_tag (commit_tag_in),
        .i_commit_val (commit_val_in),
        .o_val        (rs2_val_out),
        .o_busy       (rs2_busy_out),
        .o_tag        (rs2_tag_out)
    );
endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: expectations are queued as each step is
// driven and popped against the read ports when sampled.
module tb_reg_rename_file;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clear_in;
    logic        commit_en_in;
    logic [4:0]  commit_tag_in;
    logic [4:0]  commit_rd_in;
    logic [31:0] commit_val_in;
    logic        rename_en_in;
    logic [4:0]  rename_rd_in;
    logic [4:0]  rename_tag_in;
    logic [4:0]  rs1_addr_in;
    logic [4:0]  rs2_addr_in;
    logic [31:0] rs1_val_out;
    logic [31:0] rs2_val_out;
    logic        rs1_busy_out;
    logic        rs2_busy_out;
    logic [4:0]  rs1_tag_out;
    logic [4:0]  rs2_tag_out;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] val;
        logic        busy;
        logic [4:0]  tag;
        bit          chk_val;
        bit          chk_tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk_in = ~clk_in;

    reg_rename_file dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .clear_in      (clear_in),
        .commit_en_in  (commit_en_in),
        .commit_tag_in (commit_tag_in),
        .commit_rd_in  (commit_rd_in),
        .commit_val_in (commit_val_in),
        .rename_en_in  (rename_en_in),
        .rename_rd_in  (rename_rd_in),
        .rename_tag_in (rename_tag_in),
        .rs1_addr_in   (rs1_addr_in),
        .rs2_addr_in   (rs2_addr_in),
        .rs1_val_out   (rs1_val_out),
        .rs2_val_out   (rs2_val_out),
        .rs1_busy_out  (rs1_busy_out),
        .rs2_busy_out  (rs2_busy_out),
        .rs1_tag_out   (rs1_tag_out),
        .rs2_tag_out   (rs2_tag_out)
    );

    task automatic expect_port(input string n, input int p, input logic [31:0] v,
                               input logic b, input logic [4:0] t,
                               input bit cv, input bit ct);
        exp_t e;
        e.name = n; e.port = p; e.val = v; e.busy = b; e.tag = t;
        e.chk_val = cv; e.chk_tag = ct;
        sb.push_back(e);
    endtask

    task automatic compare(input bit wait_edge);
        exp_t        e;
        logic [31:0] ov;
        logic        ob;
        logic [4:0]  ot;
        if (wait_edge) @(negedge clk_in);
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            ov = (e.port == 1) ? rs1_val_out  : rs2_val_out;
            ob = (e.port == 1) ? rs1_busy_out : rs2_busy_out;
            ot = (e.port == 1) ? rs1_tag_out  : rs2_tag_out;
            compared++;
            assert (ob === e.busy) else begin
                mismatched++;
                $error("FAIL %s busy: observed %0b expected %0b", e.name, ob, e.busy);
            end
            if (e.chk_val) begin
                compared++;
                assert (ov === e.val) else begin
                    mismatched++;
                    $error("FAIL %s val: observed %h expected %h", e.name, ov, e.val);
                end
            end
            if (e.chk_tag) begin
                compared++;
                assert (ot === e.tag) else begin
                    mismatched++;
                    $error("FAIL %s tag: observed %0d expected %0d", e.name, ot, e.tag);
                end
            end
            $display("checked %s port%0d val=%h busy=%0b tag=%0d", e.name, e.port, ov, ob, ot);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        clear_in = 1'b0; commit_en_in = 1'b0; rename_en_in = 1'b0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [4:0] tag);
        rename_en_in = 1'b1; rename_rd_in = rd; rename_tag_in = tag;
    endtask

    task automatic do_commit(input logic [4:0] tag, input logic [4:0] rd, input logic [31:0] v);
        commit_en_in = 1'b1; commit_tag_in = tag; commit_rd_in = rd; commit_val_in = v;
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        commit_en_in = 1'b0; commit_tag_in = '0; commit_rd_in = '0; commit_val_in = '0;
        rename_en_in = 1'b0; rename_rd_in = '0; rename_tag_in = '0;
        rs1_addr_in = 5'd5; rs2_addr_in = 5'd0;
        #12;
        rst_n_in = 1'b1;
        tick();

        // Reset state and x0 immunity
        expect_port("rst_rs1_x5", 1, 32'h0, 1'b0, 5'd0, 1, 1);
        expect_port("rst_rs2_x0", 2, 32'h0, 1'b0, 5'd0, 1, 1);
        compare(1);
        do_commit(5'd1, 5'd0, 32'hFFFF_FFFF);
        expect_port("x0_commit_same", 2, 32'h0, 1'b0, 5'd0, 1, 0);
        compare(1);
        tick();
        expect_port("x0_commit_after", 2, 32'h0, 1'b0, 5'd0, 1, 0);
        compare(1);

        // Rename then bypassed commit
        do_rename(5'd3, 5'd7);
        tick();
        rs1_addr_in = 5'd3;
        expect_port("x3_renamed", 1, 32'h0, 1'b1, 5'd7, 0, 1);
        compare(1);
        tick();
        do_commit(5'd7, 5'd3, 32'h1234);
        expect_port("x3_bypass", 1, 32'h1234, 1'b0, 5'd0, 1, 0);
        compare(1);
        tick();
        expect_port("x3_stored", 1, 32'h1234, 1'b0, 5'd0, 1, 0);
        compare(1);

        // Stale commit must not release a younger rename
        do_rename(5'd4, 5'd2);
        tick();
        do_rename(5'd4, 5'd9);
        tick();
        rs1_addr_in = 5'd4;
        do_commit(5'd2, 5'd4, 32'hAA);
        expect_port("x4_no_bypass", 1, 32'h0, 1'b1, 5'd9, 1, 1);
        compare(1);
        tick();
        expect_port("x4_stale_commit", 1, 32'hAA, 1'b1, 5'd9, 1, 1);
        compare(1);

        // Same-cycle rename and commit: value written, rename wins
        do_rename(5'd6, 5'd10);
        tick();
        rs2_addr_in = 5'd6;
        do_rename(5'd6, 5'd11);
        do_commit(5'd10, 5'd6, 32'h55);
        expect_port("x6_bypass_same", 2, 32'h55, 1'b0, 5'd0, 1, 0);
        compare(1);
        tick();
        expect_port("x6_rename_wins", 2, 32'h55, 1'b1, 5'd11, 1, 1);
        compare(1);

        // Clear with commit and dropped rename
        do_rename(5'd1, 5'd1); tick();
        do_rename(5'd2, 5'd2); tick();
        do_rename(5'd8, 5'd8); tick();
        rs1_addr_in = 5'd1; rs2_addr_in = 5'd8;
        expect_port("x1_busy", 1, 32'h0, 1'b1, 5'd1, 0, 1);
        expect_port("x8_busy", 2, 32'h0, 1'b1, 5'd8, 0, 1);
        compare(1);
        clear_in = 1'b1;
        do_commit(5'd1, 5'd1, 32'h80);
        do_rename(5'd9, 5'd12);
        tick();
        rs2_addr_in = 5'd2;
        expect_port("clr_x1", 1, 32'h80, 1'b0, 5'd0, 1, 0);
        expect_port("clr_x2", 2, 32'h0, 1'b0, 5'd0, 1, 0);
        compare(1);
        rs1_addr_in = 5'd8; rs2_addr_in = 5'd9;
        expect_port("clr_x8", 1, 32'h0, 1'b0, 5'd0, 0, 0);
        expect_port("clr_x9_dropped", 2, 32'h0, 1'b0, 5'd0, 0, 0);
        compare(1);
        rs1_addr_in = 5'd4; rs2_addr_in = 5'd6;
        expect_port("clr_x4", 1, 32'hAA, 1'b0, 5'd0, 1, 0);
        expect_port("clr_x6", 2, 32'h55, 1'b0, 5'd0, 1, 0);
        compare(1);

        // rdy low freezes state; bypass still active
        do_rename(5'd10, 5'd4);
        tick();
        rdy_in = 1'b0;
        do_commit(5'd0, 5'd5, 32'hDEAD);
        do_rename(5'd7, 5'd3);
        tick();
        rs1_addr_in = 5'd5; rs2_addr_in = 5'd7;
        expect_port("frz_x5", 1, 32'h0, 1'b0, 5'd0, 1, 0);
        expect_port("frz_x7", 2, 32'h0, 1'b0, 5'd0, 1, 0);
        compare(1);
        rs1_addr_in = 5'd10;
        do_commit(5'd4, 5'd10, 32'h99);
        expect_port("frz_bypass", 1, 32'h99, 1'b0, 5'd0, 1, 0);
        compare(1);
        tick();
        expect_port("frz_x10_held", 1, 32'h0, 1'b1, 5'd4, 1, 1);
        compare(1);

        // Asynchronous reset between edges
        rdy_in = 1'b1;
        rs1_addr_in = 5'd3; rs2_addr_in = 5'd1;
        #2;
        rst_n_in = 1'b0;
        #1;
        expect_port("arst_x3", 1, 32'h0, 1'b0, 5'd0, 1, 1);
        expect_port("arst_x1", 2, 32'h0, 1'b0, 5'd0, 1, 1);
        compare(0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        do_commit(5'd0, 5'd3, 32'h77);
        tick();
        expect_port("post_rst_write", 1, 32'h77, 1'b0, 5'd0, 1, 0);
        compare(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
